// File: rtl/dram_requester.sv
// Whole-row DRAM requester: splits writes into beats and assembles read beats into a row.
// Latency: accept -> WAIT_READY -> ACTIVE (strobe) -> RESP pulse; at least 4 cycles plus DRAM time.
// Backpressure: req_ready is high only in IDLE; the DRAM side starts only when dram_ready is seen.
module dram_requester #(
  parameter int ADDRESS_LEN        = 16,
  parameter int BURST_ACCESS_WIDTH = 64,
  parameter int BURST_LEN          = 8,
  parameter int ROW_WIDTH          = BURST_LEN * BURST_ACCESS_WIDTH,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDRESS_LEN-1:0]        req_addr,
  input  logic [ROW_WIDTH-1:0]          req_wdata,
  output logic                          resp_valid,
  output logic [ROW_WIDTH-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic [ADDRESS_LEN-1:0]        dram_addr,
  output logic                          dram_read_en,
  output logic                          dram_write_en,
  output logic [BURST_ACCESS_WIDTH-1:0] dram_wdata,
  input  logic                          dram_ready,
  input  logic                          dram_complete,
  input  logic [BURST_ACCESS_WIDTH-1:0] dram_rdata,
  input  logic                          dram_valid
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int IW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_READY, ACTIVE, RESP} state_t;

  state_t                          state;
  logic                            we;
  logic                            err;
  logic [ADDRESS_LEN-1:0]          addr_q;
  logic [CW-1:0]                   beat_cnt;
  logic [TW-1:0]                   tmo_cnt;
  logic [BURST_ACCESS_WIDTH-1:0]   wbuf [BURST_LEN];
  logic [BURST_ACCESS_WIDTH-1:0]   rbuf [BURST_LEN];
  logic [ROW_WIDTH-1:0]            rbuf_flat;
  logic [ROW_WIDTH-1:0]            resp_rdata_q;
  logic                            beat_room;
  logic                            beat_take;
  logic [CW-1:0]                   beat_nxt;

  // A beat is taken only while there is room; extra beats are dropped and flagged.
  always_comb begin
    beat_room = (beat_cnt < BEAT_MAX);
    beat_take = (state == ACTIVE) && dram_valid && beat_room;
    beat_nxt  = beat_take ? beat_cnt + CW'(1) : beat_cnt;
  end

  // Flatten the read buffer so the RESP cycle can present the row directly.
  always_comb begin
    rbuf_flat = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      rbuf_flat[k*BURST_ACCESS_WIDTH +: BURST_ACCESS_WIDTH] = rbuf[k];
    end
  end

  // Request/transaction sequencing, beat capture, timeout and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we           <= 1'b0;
      err          <= 1'b0;
      addr_q       <= '0;
      beat_cnt     <= '0;
      tmo_cnt      <= '0;
      resp_rdata_q <= '0;
      for (int k = 0; k < BURST_LEN; k++) begin
        wbuf[k] <= '0;
        rbuf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we       <= req_we;
            addr_q   <= req_addr;
            err      <= 1'b0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            // rbuf is cleared so a short read returns zeros in unfilled beats.
            for (int k = 0; k < BURST_LEN; k++) begin
              wbuf[k] <= req_wdata[k*BURST_ACCESS_WIDTH +: BURST_ACCESS_WIDTH];
              rbuf[k] <= '0;
            end
            state <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (dram_ready) state <= ACTIVE;
        end
        ACTIVE: begin
          if (beat_take) begin
            if (!we) rbuf[beat_cnt[IW-1:0]] <= dram_rdata;
            beat_cnt <= beat_nxt;
          end
          if (dram_valid && !beat_room) err <= 1'b1;
          if (dram_complete) begin
            if (beat_nxt != BEAT_MAX) err <= 1'b1;
            state <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          if (!we) resp_rdata_q <= rbuf_flat;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state; the read row is visible during RESP itself.
  always_comb begin
    req_ready     = (state == IDLE);
    resp_valid    = (state == RESP);
    resp_err      = (state == RESP) && err;
    dram_read_en  = (state == ACTIVE) && !we;
    dram_write_en = (state == ACTIVE) && we;
    dram_addr     = (state != IDLE) ? addr_q : '0;
    dram_wdata    = beat_room ? wbuf[beat_cnt[IW-1:0]] : '0;
    resp_rdata    = ((state == RESP) && !we) ? rbuf_flat : resp_rdata_q;
  end

endmodule

// File: tb/tb_dram_requester.sv
// Bench for dram_requester: directed DRAM-stub scenarios with a transaction-level model.
// Outputs are compared against the model every cycle, plus literal per-scenario checks.
// The stub drives DRAM inputs on the falling edge; comparisons happen 1ns after the rising edge.
module tb_dram_requester;

  localparam int AL  = 16;
  localparam int W   = 64;
  localparam int BL  = 8;
  localparam int ROW = BL * W;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [AL-1:0]  req_addr;
  logic [ROW-1:0] req_wdata;
  logic           resp_valid;
  logic [ROW-1:0] resp_rdata;
  logic           resp_err;
  logic [AL-1:0]  dram_addr;
  logic           dram_read_en;
  logic           dram_write_en;
  logic [W-1:0]   dram_wdata;
  logic           dram_ready;
  logic           dram_complete;
  logic [W-1:0]   dram_rdata;
  logic           dram_valid;

  dram_requester #(
    .ADDRESS_LEN(AL), .BURST_ACCESS_WIDTH(W), .BURST_LEN(BL),
    .ROW_WIDTH(ROW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dram_addr(dram_addr), .dram_read_en(dram_read_en), .dram_write_en(dram_write_en),
    .dram_wdata(dram_wdata), .dram_ready(dram_ready), .dram_complete(dram_complete),
    .dram_rdata(dram_rdata), .dram_valid(dram_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [ROW-1:0] act, input logic [ROW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for a request, 1 waiting for DRAM, 2 transferring, 3 responding
  int             m_phase;
  bit             m_we;
  logic [AL-1:0]  m_addr;
  logic [ROW-1:0] m_wrow;
  logic [ROW-1:0] m_rrow;
  logic [W-1:0]   m_beats[$];
  int             m_nvalid;
  int             m_cyc;
  bit             m_err;

  function automatic logic [ROW-1:0] assemble();
    logic [ROW-1:0] r = '0;
    for (int k = 0; k < m_beats.size() && k < BL; k++) r[k*W +: W] = m_beats[k];
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_we = 0; m_addr = '0; m_wrow = '0; m_rrow = '0;
      m_beats.delete(); m_nvalid = 0; m_cyc = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
             m_we = req_we; m_addr = req_addr; m_wrow = req_wdata;
             m_beats.delete(); m_nvalid = 0; m_cyc = 0; m_err = 0;
             m_phase = 1;
           end
        1: if (dram_ready) m_phase = 2;
        2: begin
             if (dram_valid) begin
               m_nvalid++;
               m_beats.push_back(dram_rdata);
             end
             m_cyc++;
             if (dram_complete) begin
               m_err = (m_nvalid != BL);
               m_phase = 3;
             end else if (m_cyc == TMO) begin
               m_err = 1;
               m_phase = 3;
             end
           end
        default: begin
             if (!m_we) m_rrow = assemble();
             m_phase = 0;
           end
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [W-1:0] exp_wd;
    exp_wd = (m_nvalid < BL) ? m_wrow[m_nvalid*W +: W] : '0;
    chk("req_ready",     ROW'(req_ready),     ROW'(m_phase == 0));
    chk("resp_valid",    ROW'(resp_valid),    ROW'(m_phase == 3));
    chk("resp_err",      ROW'(resp_err),      ROW'(m_phase == 3 && m_err));
    chk("dram_read_en",  ROW'(dram_read_en),  ROW'(m_phase == 2 && !m_we));
    chk("dram_write_en", ROW'(dram_write_en), ROW'(m_phase == 2 && m_we));
    chk("dram_addr",     ROW'(dram_addr),     ROW'((m_phase != 0) ? m_addr : '0));
    chk("dram_wdata",    ROW'(dram_wdata),    ROW'(exp_wd));
    chk("resp_rdata",    resp_rdata,          (m_phase == 3 && !m_we) ? assemble() : m_rrow);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare_outputs();
  end

  // ---------------- directed stimulus ----------------
  int             strobe_cycles;
  int             early_strobes;
  bit             rise_ok;
  bit             got_valid;
  bit             got_err;
  logic [ROW-1:0] got_row;
  logic [W-1:0]   wd[16];
  int             nwd;

  task automatic issue(input bit we, input logic [AL-1:0] addr, input logic [ROW-1:0] wdata);
    int guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready) begin n_chk++; n_fail++; $display("FAIL issue_wait: req_ready stuck at 0, required 1"); end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble request inputs after acceptance; they must not matter.
    req_valid = 0; req_we = ~we; req_addr = 16'hFFFF; req_wdata = {BL{64'hDEAD_BEEF_0BAD_F00D}};
  endtask

  // Called in the first WAIT_READY cycle. Sends nbeats beats; completes with the last one if cmpl.
  task automatic serve(input int nbeats, input bit cmpl, input int delay);
    int guard = 0;
    strobe_cycles = 0; early_strobes = 0; nwd = 0;
    for (int i = 0; i < delay; i++) begin
      if (dram_read_en || dram_write_en) early_strobes++;
      @(negedge clk);
    end
    dram_ready = 1;
    @(negedge clk);
    dram_ready = 0;
    rise_ok = dram_read_en || dram_write_en;
    for (int i = 0; i < nbeats; i++) begin
      if (dram_read_en || dram_write_en) strobe_cycles++;
      if (dram_write_en && nwd < 16) begin wd[nwd] = dram_wdata; nwd++; end
      dram_valid = 1;
      dram_rdata = 64'h11 * (i + 1);
      dram_complete = cmpl && (i == nbeats - 1);
      @(negedge clk);
    end
    dram_valid = 0; dram_complete = 0; dram_rdata = '0;
    while (!resp_valid && guard < 100) begin
      if (dram_read_en || dram_write_en) strobe_cycles++;
      @(negedge clk);
      guard++;
    end
    got_valid = resp_valid; got_err = resp_err; got_row = resp_rdata;
    chk("resp_seen", ROW'(got_valid), ROW'(1));
    @(negedge clk);
  endtask

  logic [ROW-1:0] wrow;

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    dram_ready = 0; dram_complete = 0; dram_rdata = '0; dram_valid = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_req_ready", ROW'(req_ready), ROW'(1));
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_strobes", ROW'({dram_read_en, dram_write_en}), ROW'(0));

    // Full read of row 5
    issue(0, 16'h0005, '0);
    chk("rd_addr", ROW'(dram_addr), ROW'(16'h0005));
    serve(8, 1, 0);
    chk("rd_rise", ROW'(rise_ok), ROW'(1));
    chk("rd_err", ROW'(got_err), ROW'(0));
    chk("rd_beat0", ROW'(got_row[63:0]), ROW'(64'h11));
    chk("rd_beat7", ROW'(got_row[511:448]), ROW'(64'h88));

    // Full write of row 3
    for (int k = 0; k < BL; k++) wrow[k*W +: W] = 64'hA0 + 64'(k);
    issue(1, 16'h0003, wrow);
    serve(8, 1, 0);
    chk("wr_err", ROW'(got_err), ROW'(0));
    chk("wr_nbeats", ROW'(nwd), ROW'(8));
    for (int k = 0; k < BL; k++) chk($sformatf("wr_wdata%0d", k), ROW'(wd[k]), ROW'(64'hA0 + 64'(k)));
    chk("wr_keeps_rdata", resp_rdata[63:0], ROW'(64'h11));

    // DRAM not ready for 20 cycles
    issue(0, 16'h0010, '0);
    serve(8, 1, 20);
    chk("dly_no_early", ROW'(early_strobes), ROW'(0));
    chk("dly_rise", ROW'(rise_ok), ROW'(1));
    chk("dly_err", ROW'(got_err), ROW'(0));

    // Short read: 5 beats
    issue(0, 16'h0020, '0);
    serve(5, 1, 0);
    chk("short_err", ROW'(got_err), ROW'(1));
    chk("short_beat4", ROW'(got_row[319:256]), ROW'(64'h55));
    chk("short_tail0", ROW'(got_row[511:320]), '0);

    // Long read: 9 beats, 9th dropped
    issue(0, 16'h0021, '0);
    serve(9, 1, 0);
    chk("long_err", ROW'(got_err), ROW'(1));
    chk("long_beat7", ROW'(got_row[511:448]), ROW'(64'h88));

    // Timeout on a write that never completes
    issue(1, 16'h0030, wrow);
    serve(0, 0, 0);
    chk("tmo_strobe_cycles", ROW'(strobe_cycles), ROW'(TMO));
    chk("tmo_err", ROW'(got_err), ROW'(1));

    // Reset in the middle of a read after 3 beats
    issue(0, 16'h0040, '0);
    dram_ready = 1;
    @(negedge clk);
    dram_ready = 0;
    for (int i = 0; i < 3; i++) begin
      dram_valid = 1; dram_rdata = 64'h11 * (i + 1);
      @(negedge clk);
    end
    dram_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mrst_strobes", ROW'({dram_read_en, dram_write_en}), ROW'(0));
    chk("mrst_req_ready", ROW'(req_ready), ROW'(1));
    chk("mrst_rdata", resp_rdata, '0);
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_resp", ROW'(resp_valid), ROW'(0));
      @(negedge clk);
    end

    // Read after reset completes normally
    issue(0, 16'h0041, '0);
    serve(8, 1, 0);
    chk("post_err", ROW'(got_err), ROW'(0));
    chk("post_beat3", ROW'(got_row[255:192]), ROW'(64'h44));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
